// File: rtl/prbs_chk_galois.sv
// Serial PRBS checker for a Galois-LFSR bit stream: self-syncs, locks, then counts bit errors.
// Latency: one cycle from a valid input bit to lock_o / err_o / counter update.
// Backpressure: none; vld_i low simply skips the cycle, and the checker always accepts bits.
module prbs_chk_galois #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] POLY       = '0,
  parameter int                    LOCK_CNT   = 16,
  parameter int                    LOSS_CNT   = 8,
  parameter int                    GOOD_CLR   = 64,
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clr_i,
  input  logic                 vld_i,
  input  logic                 dat_i,
  output logic                 lock_o,
  output logic                 err_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o,
  output logic [CNT_WIDTH-1:0] bit_cnt_o
);

  localparam int W  = DATA_WIDTH;
  localparam int FW = $clog2(W + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam int RW = $clog2(GOOD_CLR + 1);

  // "_LAST" values: the counter value seen while the terminal event is being consumed
  localparam logic [FW-1:0] FILL_LAST = FW'(W - 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_CNT - 1);
  localparam logic [RW-1:0] RUN_LAST  = RW'(GOOD_CLR - 1);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   h_q, h_d;
  logic [FW-1:0]  fill_q, fill_d;
  logic [GW-1:0]  good_q, good_d;
  logic [LW-1:0]  loss_q, loss_d;
  logic [RW-1:0]  run_q, run_d;
  logic           lock_q, lock_d;
  logic           err_q, err_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;

  logic exp_bit;
  logic mis;
  logic inc_err;
  logic inc_bit;

  // Predicted next bit: the generator's output recurrence over the last W received bits
  assign exp_bit = h_q[W-1] ^ (^(h_q[W-2:0] & POLY[W-2:0]));
  assign mis     = dat_i != exp_bit;

  // Next-state and datapath decisions; nothing moves unless a valid bit arrives
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    fill_d  = fill_q;
    good_d  = good_q;
    loss_d  = loss_q;
    run_d   = run_q;
    lock_d  = lock_q;
    err_d   = 1'b0;
    inc_err = 1'b0;
    inc_bit = 1'b0;
    if (vld_i) begin
      case (state_q)
        HUNT: begin
          h_d = {h_q[W-2:0], dat_i};
          if (fill_q == FILL_LAST) begin
            state_d = SYNC;
            fill_d  = '0;
            good_d  = '0;
          end else begin
            fill_d = fill_q + FW'(1);
          end
        end
        SYNC: begin
          h_d = {h_q[W-2:0], dat_i};
          // an all-zero history predicts zeros forever, so it must never count as a match
          if (!mis && (|h_q)) begin
            if (good_q == GOOD_LAST) begin
              state_d = LOCKED;
              lock_d  = 1'b1;
              good_d  = '0;
              loss_d  = '0;
              run_d   = '0;
            end else begin
              good_d = good_q + GW'(1);
            end
          end else begin
            good_d = '0;
          end
        end
        LOCKED: begin
          // flywheel: feed back the prediction so a flipped bit is counted once only
          h_d     = {h_q[W-2:0], exp_bit};
          inc_bit = 1'b1;
          if (mis) begin
            err_d   = 1'b1;
            inc_err = 1'b1;
            run_d   = '0;
            if (loss_q == LOSS_LAST) begin
              state_d = HUNT;
              lock_d  = 1'b0;
              fill_d  = '0;
              loss_d  = '0;
            end else begin
              loss_d = loss_q + LW'(1);
            end
          end else if (run_q == RUN_LAST) begin
            loss_d = '0;
            run_d  = '0;
          end else begin
            run_d = run_q + RW'(1);
          end
        end
        default: begin
          state_d = HUNT;
          fill_d  = '0;
          lock_d  = 1'b0;
        end
      endcase
    end
  end

  // Saturating statistics; a clear keeps only this cycle's increment
  always_comb begin
    err_cnt_d = err_cnt_q;
    bit_cnt_d = bit_cnt_q;
    if (clr_i) begin
      err_cnt_d = {{(CNT_WIDTH-1){1'b0}}, inc_err};
      bit_cnt_d = {{(CNT_WIDTH-1){1'b0}}, inc_bit};
    end else begin
      if (inc_err && !(&err_cnt_q)) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
      if (inc_bit && !(&bit_cnt_q)) bit_cnt_d = bit_cnt_q + CNT_WIDTH'(1);
    end
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= HUNT;
      h_q       <= '0;
      fill_q    <= '0;
      good_q    <= '0;
      loss_q    <= '0;
      run_q     <= '0;
      lock_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      fill_q    <= fill_d;
      good_q    <= good_d;
      loss_q    <= loss_d;
      run_q     <= run_d;
      lock_q    <= lock_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign lock_o    = lock_q;
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;
  assign bit_cnt_o = bit_cnt_q;

endmodule

// File: tb/tb_prbs_chk_galois.sv
// Bench for prbs_chk_galois: W=4, x^4+x^3+1 stream, directed scenarios plus a random soak.
// Outputs sampled 1 time unit after the active edge and compared to a queue-based model.
// Inputs driven on the falling edge; no backpressure exists on this block.
module tb_prbs_chk_galois;

  localparam int W    = 4;
  localparam int LOCK = 8;
  localparam int LOSS = 4;
  localparam int GCLR = 16;
  localparam int CW   = 8;
  localparam int CMAX = 255;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          clr_i;
  logic          vld_i;
  logic          dat_i;
  logic          lock_o;
  logic          err_o;
  logic [CW-1:0] err_cnt_o;
  logic [CW-1:0] bit_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  prbs_chk_galois #(
    .DATA_WIDTH(W),
    .POLY      (4'h1),
    .LOCK_CNT  (LOCK),
    .LOSS_CNT  (LOSS),
    .GOOD_CLR  (GCLR),
    .CNT_WIDTH (CW)
  ) dut (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clr_i    (clr_i),
    .vld_i    (vld_i),
    .dat_i    (dat_i),
    .lock_o   (lock_o),
    .err_o    (err_o),
    .err_cnt_o(err_cnt_o),
    .bit_cnt_o(bit_cnt_o)
  );

  // ---------------- generator: one period of the m-sequence s[n]=s[n-1]^s[n-4]
  bit seq [15];
  int pos;

  task automatic build_seq();
    bit [3:0] seed;
    seed = 4'b1000;
    for (int i = 0; i < 4; i++) seq[i] = seed[i];
    for (int i = 4; i < 15; i++) seq[i] = seq[i-1] ^ seq[i-4];
  endtask

  task automatic next_gen(output bit b);
    b   = seq[pos];
    pos = (pos + 1) % 15;
  endtask

  // ---------------- reference model
  bit m_hist[$];
  int m_fill, m_good, m_loss, m_run, m_errc, m_bitc;
  bit m_lock, m_err;

  task automatic model_reset();
    m_hist.delete();
    m_fill = 0; m_good = 0; m_loss = 0; m_run = 0;
    m_errc = 0; m_bitc = 0; m_lock = 0; m_err = 0;
  endtask

  task automatic push_hist(input bit b);
    m_hist.push_back(b);
    if (m_hist.size() > W) void'(m_hist.pop_front());
  endtask

  task automatic model_step(input bit v, input bit d, input bit c);
    bit e, nz;
    int ie, ib;
    ie = 0; ib = 0; m_err = 0;
    if (v) begin
      if (!m_lock && m_fill < W) begin
        push_hist(d);
        m_fill++;
        m_good = 0;
      end else if (!m_lock) begin
        e  = m_hist[0] ^ m_hist[3];
        nz = m_hist[0] | m_hist[1] | m_hist[2] | m_hist[3];
        push_hist(d);
        if (d == e && nz) begin
          m_good++;
          if (m_good == LOCK) begin
            m_lock = 1; m_loss = 0; m_run = 0;
          end
        end else m_good = 0;
      end else begin
        e = m_hist[0] ^ m_hist[3];
        push_hist(e);
        ib = 1;
        if (d != e) begin
          m_err = 1; ie = 1; m_loss++; m_run = 0;
          if (m_loss == LOSS) begin
            m_lock = 0; m_fill = 0;
          end
        end else begin
          m_run++;
          if (m_run == GCLR) begin
            m_loss = 0; m_run = 0;
          end
        end
      end
    end
    if (c) begin
      m_errc = ie; m_bitc = ib;
    end else begin
      m_errc = (m_errc + ie > CMAX) ? CMAX : m_errc + ie;
      m_bitc = (m_bitc + ib > CMAX) ? CMAX : m_bitc + ib;
    end
  endtask

  // ---------------- checking
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input bit v, input bit d, input bit c);
    @(negedge clk_i);
    vld_i = v; dat_i = d; clr_i = c;
    @(posedge clk_i);
    model_step(v, d, c);
    #1;
    check_val("lock", {31'd0, lock_o}, {31'd0, m_lock});
    check_val("err",  {31'd0, err_o},  {31'd0, m_err});
    check_val("err_cnt", {24'd0, err_cnt_o}, m_errc);
    check_val("bit_cnt", {24'd0, bit_cnt_o}, m_bitc);
  endtask

  task automatic send(input bit flip);
    bit b;
    next_gen(b);
    cyc(1'b1, b ^ flip, 1'b0);
  endtask

  // async reset asserted mid-cycle; outputs must clear without a clock edge
  task automatic do_reset();
    @(negedge clk_i);
    #2 rst_n_i = 1'b0;
    #1;
    check_val("rst_lock", {31'd0, lock_o}, 0);
    check_val("rst_err",  {31'd0, err_o}, 0);
    check_val("rst_err_cnt", {24'd0, err_cnt_o}, 0);
    check_val("rst_bit_cnt", {24'd0, bit_cnt_o}, 0);
    model_reset();
    vld_i = 1'b0; dat_i = 1'b0; clr_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    pos = $urandom_range(0, 14);
  endtask

  task automatic acquire(input string tag);
    for (int i = 1; i <= 12; i++) begin
      send(1'b0);
      if (i == 11) check_val({tag, "_pre"}, {31'd0, lock_o}, 0);
      if (i == 12) check_val({tag, "_lock"}, {31'd0, lock_o}, 1);
    end
  endtask

  initial begin
    int need, flips, nv;
    bit b, v, d;
    rst_n_i = 1'b1; vld_i = 1'b0; dat_i = 1'b0; clr_i = 1'b0;
    build_seq();
    pos = 0;
    model_reset();

    // 1: acquisition on a clean stream
    do_reset();
    acquire("acq");
    check_val("acq_err_cnt", {24'd0, err_cnt_o}, 0);
    for (int i = 0; i < 5; i++) send(1'b0);
    check_val("acq_bit_cnt", {24'd0, bit_cnt_o}, 5);

    // 2: one flipped bit after lock
    send(1'b1);
    check_val("flip_pulse", {31'd0, err_o}, 1);
    send(1'b0);
    check_val("flip_pulse_end", {31'd0, err_o}, 0);
    check_val("flip_err_cnt", {24'd0, err_cnt_o}, 1);
    check_val("flip_lock", {31'd0, lock_o}, 1);

    // 3: four flips within ten bits drop lock, clean stream relocks after 12 bits
    do_reset();
    acquire("loss_acq");
    flips = 0;
    for (int i = 0; i < 10 && flips < LOSS; i++) begin
      need = LOSS - flips;
      if ($urandom_range(0, 9 - i) < need) begin
        flips++;
        if (flips == LOSS) check_val("loss_hold", {31'd0, lock_o}, 1);
        send(1'b1);
      end else send(1'b0);
    end
    check_val("loss_drop", {31'd0, lock_o}, 0);
    acquire("relock");

    // 4: a long clean run forgives earlier errors
    do_reset();
    acquire("run_acq");
    for (int i = 0; i < 3; i++) send(1'b1);
    for (int i = 0; i < GCLR; i++) send(1'b0);
    for (int i = 0; i < 3; i++) send(1'b1);
    check_val("run_lock", {31'd0, lock_o}, 1);
    check_val("run_err_cnt", {24'd0, err_cnt_o}, 6);

    // 5a: all-zero stream never locks
    do_reset();
    for (int i = 0; i < 60; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      check_val("zero_lock", {31'd0, lock_o}, 0);
    end

    // 5b: clean stream with gaps locks after 12 valid bits
    do_reset();
    nv = 0;
    for (int t = 0; t < 400 && nv < 12; t++) begin
      v = $urandom_range(0, 1);
      d = $urandom_range(0, 1);
      if (v) begin
        next_gen(b);
        d = b;
        nv++;
      end
      cyc(v, d, 1'b0);
      if (v && nv == 11) check_val("gap_pre", {31'd0, lock_o}, 0);
      if (v && nv == 12) check_val("gap_lock", {31'd0, lock_o}, 1);
    end
    check_val("gap_bits", nv, 12);

    // 6: saturation, then clear with a coincident error
    do_reset();
    acquire("sat_acq");
    for (int k = 0; k < 100; k++) begin
      for (int i = 0; i < 3; i++) send(1'b1);
      for (int i = 0; i < GCLR; i++) send(1'b0);
    end
    check_val("sat_lock", {31'd0, lock_o}, 1);
    check_val("sat_err_cnt", {24'd0, err_cnt_o}, CMAX);
    check_val("sat_bit_cnt", {24'd0, bit_cnt_o}, CMAX);
    next_gen(b);
    cyc(1'b1, ~b, 1'b1);
    check_val("clr_err_cnt", {24'd0, err_cnt_o}, 1);
    check_val("clr_bit_cnt", {24'd0, bit_cnt_o}, 1);

    // soak: random gaps, flips and clears, with one mid-stream reset
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      if (t == 1500) do_reset();
      v = ($urandom_range(0, 3) != 0);
      d = $urandom_range(0, 1);
      if (v) begin
        next_gen(b);
        d = b ^ ($urandom_range(0, 15) == 0);
      end
      cyc(v, d, $urandom_range(0, 63) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
